mux2_rr_arbiter: RTL and testbench

- Sequencing controller for a shared 2-input datapath mux.
- Arbitrates two requesters with round-robin priority, bounded grant hold, and registered output.
- Drives the mux select `s0` and returns registered mux data to the consumer.
- Sits between two request sources and the single shared downstream sink.

---
 rtl/mux2_rr_arbiter_if.sv | 26 ++
 rtl/mux2_rr_arbiter.sv | 126 ++++++++++++
 tb/tb_mux2_rr_arbiter.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/mux2_rr_arbiter_if.sv
// Bundle of request, data and grant signals between two requesters and the
// shared-mux arbiter. The arbiter uses the slave modport and the request side uses the master modport.
interface mux2_rr_arbiter_if #(
    parameter int unsigned WIDTH = 8
);
    logic             req0;
    logic             req1;
    logic [WIDTH-1:0] i0;
    logic [WIDTH-1:0] i1;
    logic             gnt0;
    logic             gnt1;
    logic             s0;
    logic [WIDTH-1:0] out;
    logic             out_valid;
    logic             busy;

    modport master (
        output req0, req1, i0, i1,
        input  gnt0, gnt1, s0, out, out_valid, busy
    );

    modport slave (
        input  req0, req1, i0, i1,
        output gnt0, gnt1, s0, out, out_valid, busy
    );
endinterface

// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter for a shared 2-input mux: bounded grant hold,
// registered select, and registered mux output with a valid flag.
module mux2_rr_arbiter #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic               clk,
    input  logic               rst,
    mux2_rr_arbiter_if.slave   bus
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_GRANT0 = 2'd1;
    localparam logic [1:0] ST_GRANT1 = 2'd2;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    logic [1:0]       r_state;
    logic             r_s0;
    logic             r_last;
    logic [7:0]       r_hold_cnt;
    logic [WIDTH-1:0] r_out;
    logic             r_out_valid;

    logic [1:0]       w_state_nxt;
    logic             w_s0_nxt;
    logic             w_last_nxt;
    logic [7:0]       w_hold_nxt;
    logic             w_enter;
    logic             w_enter_side;
    logic             w_cur_side;
    logic             w_own_req;
    logic             w_oth_req;
    logic             w_hold_expired;
    logic             w_gnt0;
    logic             w_gnt1;
    logic             w_busy;

    assign w_gnt0         = (r_state == ST_GRANT0);
    assign w_gnt1         = (r_state == ST_GRANT1);
    assign w_busy         = w_gnt0 | w_gnt1;
    assign w_hold_expired = (r_hold_cnt == HOLD_LAST);

    // Both grant states share one path: "own" is the holder's request and "oth" is the other requester's.
    assign w_cur_side = w_gnt1;
    assign w_own_req  = w_cur_side ? bus.req1 : bus.req0;
    assign w_oth_req  = w_cur_side ? bus.req0 : bus.req1;

    always_comb begin
        w_state_nxt  = r_state;
        w_s0_nxt     = r_s0;
        w_last_nxt   = r_last;
        w_hold_nxt   = r_hold_cnt;
        w_enter      = 1'b0;
        w_enter_side = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (bus.req0 && bus.req1) begin
                    w_enter      = 1'b1;
                    w_enter_side = ~r_last;
                end else if (bus.req0) begin
                    w_enter      = 1'b1;
                    w_enter_side = 1'b0;
                end else if (bus.req1) begin
                    w_enter      = 1'b1;
                    w_enter_side = 1'b1;
                end
            end
            ST_GRANT0, ST_GRANT1: begin
                if (w_oth_req && (!w_own_req || w_hold_expired)) begin
                    w_enter      = 1'b1;
                    w_enter_side = ~w_cur_side;
                end else if (!w_own_req) begin
                    w_state_nxt = ST_IDLE;
                end else if (!w_hold_expired) begin
                    // Counter saturates at MAX_HOLD-1 while the holder runs alone.
                    w_hold_nxt = r_hold_cnt + 8'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (w_enter) begin
            w_state_nxt = w_enter_side ? ST_GRANT1 : ST_GRANT0;
            w_s0_nxt    = w_enter_side;
            w_last_nxt  = w_enter_side;
            w_hold_nxt  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_s0       <= 1'b0;
            r_last     <= 1'b1;
            r_hold_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_s0       <= w_s0_nxt;
            r_last     <= w_last_nxt;
            r_hold_cnt <= w_hold_nxt;
        end
    end

    // Captures the data that the granted requester presents during its grant cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= w_busy;
            if (w_busy) begin
                r_out <= r_s0 ? bus.i1 : bus.i0;
            end
        end
    end

    assign bus.gnt0      = w_gnt0;
    assign bus.gnt1      = w_gnt1;
    assign bus.s0        = r_s0;
    assign bus.out       = r_out;
    assign bus.out_valid = r_out_valid;
    assign bus.busy      = w_busy;
endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Randomised and directed bench for mux2_rr_arbiter. Two instances, with MAX_HOLD=4 and
// MAX_HOLD=1, receive the same stimulus and are checked against an owner/run-length model.
module tb_mux2_rr_arbiter;
    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         t_req0;
    logic         t_req1;
    logic [W-1:0] t_i0;
    logic [W-1:0] t_i1;

    int n_checks = 0;
    int n_errs   = 0;

    always #5 clk = ~clk;

    mux2_rr_arbiter_if #(.WIDTH(W)) bus4 ();
    mux2_rr_arbiter_if #(.WIDTH(W)) bus1 ();

    assign bus4.req0 = t_req0;
    assign bus4.req1 = t_req1;
    assign bus4.i0   = t_i0;
    assign bus4.i1   = t_i1;
    assign bus1.req0 = t_req0;
    assign bus1.req1 = t_req1;
    assign bus1.i0   = t_i0;
    assign bus1.i1   = t_i1;

    mux2_rr_arbiter #(.WIDTH(W), .MAX_HOLD(4)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4.slave)
    );

    mux2_rr_arbiter #(.WIDTH(W), .MAX_HOLD(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    // Model: who owns the mux (-1 = nobody), how many consecutive cycles it has held the grant,
    // and whose turn it is at the next tie.
    int           m_owner [2];
    int           m_run   [2];
    int           m_pref  [2];
    logic         m_s0    [2];
    logic [W-1:0] m_out   [2];
    logic         m_ov    [2];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            int h;
            h = (k == 0) ? 4 : 1;
            if (rst) begin
                m_owner[k] = -1;
                m_run[k]   = 0;
                m_pref[k]  = 0;
                m_s0[k]    = 1'b0;
                m_out[k]   = '0;
                m_ov[k]    = 1'b0;
            end else begin
                int x;
                int y;
                logic rx;
                logic ry;
                if (m_owner[k] >= 0) begin
                    m_out[k] = (m_owner[k] == 1) ? t_i1 : t_i0;
                    m_ov[k]  = 1'b1;
                end else begin
                    m_ov[k] = 1'b0;
                end
                if (m_owner[k] < 0) begin
                    if (t_req0 && t_req1) m_owner[k] = m_pref[k];
                    else if (t_req0)      m_owner[k] = 0;
                    else if (t_req1)      m_owner[k] = 1;
                    if (m_owner[k] >= 0) begin
                        m_run[k]  = 1;
                        m_pref[k] = 1 - m_owner[k];
                        m_s0[k]   = (m_owner[k] == 1);
                    end
                end else begin
                    x  = m_owner[k];
                    y  = 1 - x;
                    rx = (x == 1) ? t_req1 : t_req0;
                    ry = (y == 1) ? t_req1 : t_req0;
                    if (ry && (!rx || m_run[k] >= h)) begin
                        m_owner[k] = y;
                        m_run[k]   = 1;
                        m_pref[k]  = x;
                        m_s0[k]    = (y == 1);
                    end else if (!rx) begin
                        m_owner[k] = -1;
                    end else begin
                        m_run[k]++;
                    end
                end
            end
        end
    endtask

    task automatic check_inst(input int k, input logic g0, input logic g1, input logic s0,
                              input logic [W-1:0] out, input logic ov, input logic busy);
        string p;
        p = (k == 0) ? "h4" : "h1";
        check_eq({p, "_gnt0"}, 32'(g0), 32'(m_owner[k] == 0));
        check_eq({p, "_gnt1"}, 32'(g1), 32'(m_owner[k] == 1));
        check_eq({p, "_s0"},   32'(s0), 32'(m_s0[k]));
        check_eq({p, "_out"},  32'(out), 32'(m_out[k]));
        check_eq({p, "_ovld"}, 32'(ov), 32'(m_ov[k]));
        check_eq({p, "_busy"}, 32'(busy), 32'(m_owner[k] >= 0));
        check_eq({p, "_excl"}, 32'(g0 & g1), 32'd0);
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_inst(0, bus4.gnt0, bus4.gnt1, bus4.s0, bus4.out, bus4.out_valid, bus4.busy);
        check_inst(1, bus1.gnt0, bus1.gnt1, bus1.s0, bus1.out, bus1.out_valid, bus1.busy);
    endtask

    task automatic drive(input logic r, input logic q0, input logic q1,
                         input logic [W-1:0] d0, input logic [W-1:0] d1);
        rst    = r;
        t_req0 = q0;
        t_req1 = q1;
        t_i0   = d0;
        t_i1   = d1;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; t_req0 = 1'b1; t_req1 = 1'b1; t_i0 = 8'hA5; t_i1 = 8'h5A;
        for (int k = 0; k < 2; k++) begin
            m_owner[k] = -1; m_run[k] = 0; m_pref[k] = 0;
            m_s0[k] = 1'b0; m_out[k] = '0; m_ov[k] = 1'b0;
        end

        // Reset with both requests asserted
        drive(1'b1, 1'b1, 1'b1, 8'hA5, 8'h5A);
        drive(1'b1, 1'b1, 1'b1, 8'hA5, 8'h5A);
        check_eq("rst_gnt0", 32'(bus4.gnt0), 32'd0);
        check_eq("rst_gnt1", 32'(bus4.gnt1), 32'd0);
        check_eq("rst_s0",   32'(bus4.s0), 32'd0);
        check_eq("rst_out",  32'(bus4.out), 32'h00);
        check_eq("rst_ovld", 32'(bus4.out_valid), 32'd0);
        check_eq("rst_busy", 32'(bus4.busy), 32'd0);

        // Single requester streaming 11,22,33 and then releasing
        drive(1'b0, 1'b1, 1'b0, 8'h11, 8'h00);
        check_eq("single_gnt0", 32'(bus4.gnt0), 32'd1);
        drive(1'b0, 1'b1, 1'b0, 8'h11, 8'h00);
        check_eq("single_out1", 32'(bus4.out), 32'h11);
        drive(1'b0, 1'b1, 1'b0, 8'h22, 8'h00);
        check_eq("single_out2", 32'(bus4.out), 32'h22);
        drive(1'b0, 1'b0, 1'b0, 8'h33, 8'h00);
        check_eq("single_out3", 32'(bus4.out), 32'h33);
        check_eq("drop_gnt0",   32'(bus4.gnt0), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 8'h44, 8'h00);
        check_eq("drop_ovld", 32'(bus4.out_valid), 32'd0);
        check_eq("drop_hold", 32'(bus4.out), 32'h33);

        // Continuous tie: MAX_HOLD=4 rotates every 4 cycles and MAX_HOLD=1 rotates every cycle
        drive(1'b1, 1'b0, 1'b0, 8'h0F, 8'hF0);
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b1, 1'b1, 8'h0F, 8'hF0);
            check_eq("tie_h4_gnt1", 32'(bus4.gnt1), 32'((i / 4) % 2));
            check_eq("tie_h1_gnt1", 32'(bus1.gnt1), 32'(i % 2));
            if (i > 0) check_eq("tie_h1_out", 32'(bus1.out), (i % 2 == 1) ? 32'h0F : 32'hF0);
        end

        // Hand-off from GRANT1 to GRANT0 with no idle bubble, then the next tie after IDLE
        drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        drive(1'b0, 1'b0, 1'b1, 8'h01, 8'h02);
        drive(1'b0, 1'b1, 1'b1, 8'h03, 8'h04);
        drive(1'b0, 1'b1, 1'b0, 8'h05, 8'h06);
        check_eq("handoff_gnt0", 32'(bus4.gnt0), 32'd1);
        check_eq("handoff_busy", 32'(bus4.busy), 32'd1);
        drive(1'b0, 1'b0, 1'b0, 8'h07, 8'h08);
        drive(1'b0, 1'b1, 1'b1, 8'h09, 8'h0A);
        check_eq("tie_after_idle_gnt1", 32'(bus4.gnt1), 32'd1);

        // Reset during a grant while both requests stay asserted
        drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b1, 8'h21, 8'h12);
        drive(1'b1, 1'b1, 1'b1, 8'h21, 8'h12);
        check_eq("midrst_busy", 32'(bus4.busy), 32'd0);
        check_eq("midrst_out",  32'(bus4.out), 32'h00);
        drive(1'b0, 1'b1, 1'b1, 8'h21, 8'h12);
        check_eq("midrst_regrant0", 32'(bus4.gnt0), 32'd1);

        // Random traffic biased toward sustained requests
        for (int i = 0; i < 500; i++) begin
            drive(($urandom_range(0, 63) == 0),
                  ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 3) != 0),
                  W'($urandom), W'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errs);
        $finish;
    end
endmodule
